// File: rtl/axi_adc_spi_pkg.sv
// Shared definitions for the AXI4-Lite ADC serial-control master:
// register offsets, FSM states, response codes and register bit positions.
package axi_adc_spi_pkg;

    localparam logic [7:0] ADDR_TXDATA = 8'h00;
    localparam logic [7:0] ADDR_CTRL   = 8'h04;
    localparam logic [7:0] ADDR_CLKDIV = 8'h08;
    localparam logic [7:0] ADDR_STATUS = 8'h0C;
    localparam logic [7:0] ADDR_RXDATA = 8'h10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CTRL_START_BIT   = 0;
    localparam int CTRL_CS_LSB      = 4;
    localparam int CTRL_RD_MODE_BIT = 8;

    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_DONE_BIT  = 1;
    localparam int STAT_CSERR_BIT = 2;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCLK_HI,
        SCLK_LO,
        HOLD
    } spi_state_e;

    // Byte-lane merge of a write into the current 32-bit register image.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_adc_spi_master_if.sv
// AXI4-Lite channel bundle between the PS interconnect (master) and the
// ADC serial-control block (slave).
interface axi_adc_spi_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_adc_spi_shifter.sv
// Serial engine: half-period divider, frame FSM and TX/RX shift registers.
// MISO capture and RD_MODE are present only with AXI_ADC_SPI_READBACK_EN.
module axi_adc_spi_shifter
    import axi_adc_spi_pkg::*;
#(
    parameter int FRAME_W  = 24,
    parameter int NUM_CS   = 2,
    parameter int CLKDIV_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [2:0]          cs_sel,
    input  logic [FRAME_W-1:0]  tx,
    input  logic [CLKDIV_W-1:0] clkdiv,
    input  logic                rd_mode,
    output logic [FRAME_W-1:0]  rx,
    output logic                busy,
    output logic                done,
    output logic                sclk,
    output logic [NUM_CS-1:0]   sen_n,
    output logic                sdout,
    input  logic                sdin
);

    localparam int BIT_W = $clog2(FRAME_W + 1);

    spi_state_e            state_q, state_d;
    logic [CLKDIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [FRAME_W-1:0]    sh_q, sh_d;
    logic [2:0]            cs_q, cs_d;
    logic                  sclk_q, sclk_d;
    logic                  sdout_q, sdout_d;
    logic [NUM_CS-1:0]     sen_n_q, sen_n_d;
    logic                  last_half;
    logic                  enter_hi;
    logic                  active_d;
    logic [FRAME_W-1:0]    load_val;

`ifdef AXI_ADC_SPI_READBACK_EN
    localparam logic [FRAME_W-1:0] LOW_MASK =
        FRAME_W'((64'd1 << (FRAME_W - 8)) - 64'd1);
    assign load_val = rd_mode ? (tx & ~LOW_MASK) : tx;
`else
    logic unused_ok;
    assign load_val  = tx;
    assign unused_ok = ^{rd_mode, sdin};
`endif

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        cs_d      = cs_q;
        enter_hi  = 1'b0;
        done      = 1'b0;
        last_half = (div_q == clkdiv);

        if (state_q == IDLE) begin
            if (start) begin
                state_d = SETUP;
                div_d   = '0;
                bit_d   = '0;
                cs_d    = cs_sel;
                sh_d    = load_val;
            end
        end else if (!last_half) begin
            div_d = div_q + 1'b1;
        end else begin
            div_d = '0;
            case (state_q)
                SETUP: begin
                    state_d  = SCLK_HI;
                    bit_d    = bit_q + 1'b1;
                    enter_hi = 1'b1;
                end
                SCLK_HI: begin
                    state_d = SCLK_LO;
                    sh_d    = sh_q << 1;
                end
                SCLK_LO: begin
                    if (bit_q == BIT_W'(FRAME_W)) begin
                        state_d = HOLD;
                    end else begin
                        state_d  = SCLK_HI;
                        bit_d    = bit_q + 1'b1;
                        enter_hi = 1'b1;
                    end
                end
                HOLD: begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end

        // Pin values are registered from the next state so they change
        // on the same edge as the state and never glitch.
        active_d = (state_d == SETUP) || (state_d == SCLK_HI) || (state_d == SCLK_LO);
        sclk_d   = (state_d == SCLK_HI);
        sen_n_d  = active_d ? ~(NUM_CS'(1) << cs_d) : '1;
        sdout_d  = active_d & sh_d[FRAME_W-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            cs_q    <= '0;
            sclk_q  <= 1'b0;
            sdout_q <= 1'b0;
            sen_n_q <= '1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            sdout_q <= sdout_d;
            sen_n_q <= sen_n_d;
        end
    end

`ifdef AXI_ADC_SPI_READBACK_EN
    logic [FRAME_W-1:0] rx_sh_q, rx_sh_d;
    logic [FRAME_W-1:0] rx_q, rx_d;

    always_comb begin
        rx_sh_d = rx_sh_q;
        rx_d    = rx_q;
        if (state_q == IDLE && start) rx_sh_d = '0;
        else if (enter_hi)            rx_sh_d = {rx_sh_q[FRAME_W-2:0], sdin};
        if (done) rx_d = rx_sh_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sh_q <= '0;
            rx_q    <= '0;
        end else begin
            rx_sh_q <= rx_sh_d;
            rx_q    <= rx_d;
        end
    end

    assign rx = rx_q;
`else
    assign rx = '0;
`endif

    assign busy  = (state_q != IDLE);
    assign sclk  = sclk_q;
    assign sen_n = sen_n_q;
    assign sdout = sdout_q;

endmodule

// File: rtl/axi_adc_spi_master.sv
// AXI4-Lite register file driving the ADC serial-control shifter.
// Define AXI_ADC_SPI_READBACK_EN to add MISO capture, RXDATA and RD_MODE.
module axi_adc_spi_master
    import axi_adc_spi_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter int FRAME_W            = 24,
    parameter int NUM_CS             = 2,
    parameter int CLKDIV_W           = 8
) (
    input  logic                 S_AXI_ACLK,
    input  logic                 S_AXI_RESET,
    axi_adc_spi_master_if.slave  s_axi,
    output logic                 spi_sclk,
    output logic [NUM_CS-1:0]    spi_sen_n,
    output logic                 spi_sdout,
    input  logic                 spi_sdin
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;

    logic                          awready_q, awready_d;
    logic                          bvalid_q, bvalid_d;
    logic [1:0]                    bresp_q, bresp_d;
    logic                          arready_q, arready_d;
    logic                          rvalid_q, rvalid_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [FRAME_W-1:0]  txdata_q, txdata_d;
    logic [2:0]          cs_sel_q, cs_sel_d;
    logic                rd_mode_q, rd_mode_d;
    logic [CLKDIV_W-1:0] clkdiv_q, clkdiv_d;
    logic                done_q, done_d;
    logic                cserr_q, cserr_d;

    logic [AW-1:0]       wr_addr, rd_addr;
    logic                wr_en, rd_en, wr_err, wr_ok;
    logic                hit_tx, hit_ctrl, hit_div, hit_stat;
    logic [31:0]         tx_new, ctrl_new, div_new, stat_clr, ctrl_old;
    logic                start_req, cs_ok, start;
    logic                busy, shift_done;
    logic [FRAME_W-1:0]  rx;
    logic                unused_ok;

    assign wr_addr  = {s_axi.awaddr[AW-1:2], 2'b00};
    assign rd_addr  = {s_axi.araddr[AW-1:2], 2'b00};
    assign wr_en    = awready_q & s_axi.awvalid & s_axi.wvalid;
    assign rd_en    = arready_q & s_axi.arvalid;
    assign hit_tx   = (wr_addr == AW'(ADDR_TXDATA));
    assign hit_ctrl = (wr_addr == AW'(ADDR_CTRL));
    assign hit_div  = (wr_addr == AW'(ADDR_CLKDIV));
    assign hit_stat = (wr_addr == AW'(ADDR_STATUS));

    // Configuration is frozen for the whole frame; only STATUS may be touched.
    assign wr_err = wr_en & busy & (hit_tx | hit_ctrl | hit_div);
    assign wr_ok  = wr_en & ~wr_err;

    assign ctrl_old = (32'(cs_sel_q) << CTRL_CS_LSB) | (32'(rd_mode_q) << CTRL_RD_MODE_BIT);
    assign tx_new   = apply_wstrb(32'(txdata_q), s_axi.wdata, s_axi.wstrb);
    assign ctrl_new = apply_wstrb(ctrl_old, s_axi.wdata, s_axi.wstrb);
    assign div_new  = apply_wstrb(32'(clkdiv_q), s_axi.wdata, s_axi.wstrb);
    assign stat_clr = apply_wstrb(32'd0, s_axi.wdata, s_axi.wstrb);

    assign start_req = wr_ok & hit_ctrl & ctrl_new[CTRL_START_BIT];
    assign cs_ok     = ({1'b0, ctrl_new[CTRL_CS_LSB +: 3]} < 4'(NUM_CS));
    assign start     = start_req & cs_ok;

    always_comb begin
        awready_d = s_axi.awvalid & s_axi.wvalid & ~bvalid_q & ~awready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        arready_d = s_axi.arvalid & ~rvalid_q & ~arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        txdata_d  = txdata_q;
        cs_sel_d  = cs_sel_q;
        rd_mode_d = rd_mode_q;
        clkdiv_d  = clkdiv_q;
        done_d    = done_q;
        cserr_d   = cserr_q;

        if (wr_en) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_err ? RESP_SLVERR : RESP_OKAY;
        end else if (s_axi.bready) begin
            bvalid_d = 1'b0;
        end

        if (wr_ok && hit_tx)  txdata_d = tx_new[FRAME_W-1:0];
        if (wr_ok && hit_div) clkdiv_d = div_new[CLKDIV_W-1:0];
        if (wr_ok && hit_ctrl) begin
            cs_sel_d = ctrl_new[CTRL_CS_LSB +: 3];
`ifdef AXI_ADC_SPI_READBACK_EN
            rd_mode_d = ctrl_new[CTRL_RD_MODE_BIT];
`else
            rd_mode_d = 1'b0;
`endif
        end

        // Clears first so a same-cycle set takes priority.
        if (wr_ok && hit_stat && stat_clr[STAT_DONE_BIT])  done_d  = 1'b0;
        if (wr_ok && hit_stat && stat_clr[STAT_CSERR_BIT]) cserr_d = 1'b0;
        if (shift_done)           done_d  = 1'b1;
        if (start_req && !cs_ok)  cserr_d = 1'b1;

        if (rd_en) begin
            rvalid_d = 1'b1;
            case (rd_addr)
                AW'(ADDR_TXDATA): rdata_d = C_S_AXI_DATA_WIDTH'(txdata_q);
                AW'(ADDR_CTRL):   rdata_d = C_S_AXI_DATA_WIDTH'(ctrl_old);
                AW'(ADDR_CLKDIV): rdata_d = C_S_AXI_DATA_WIDTH'(clkdiv_q);
                AW'(ADDR_STATUS): rdata_d = C_S_AXI_DATA_WIDTH'({cserr_q, done_q, busy});
                AW'(ADDR_RXDATA): rdata_d = C_S_AXI_DATA_WIDTH'(rx);
                default:          rdata_d = '0;
            endcase
        end else if (s_axi.rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_RESET) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            txdata_q  <= '0;
            cs_sel_q  <= '0;
            rd_mode_q <= 1'b0;
            clkdiv_q  <= '0;
            done_q    <= 1'b0;
            cserr_q   <= 1'b0;
        end else begin
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            txdata_q  <= txdata_d;
            cs_sel_q  <= cs_sel_d;
            rd_mode_q <= rd_mode_d;
            clkdiv_q  <= clkdiv_d;
            done_q    <= done_d;
            cserr_q   <= cserr_d;
        end
    end

    axi_adc_spi_shifter #(
        .FRAME_W  (FRAME_W),
        .NUM_CS   (NUM_CS),
        .CLKDIV_W (CLKDIV_W)
    ) u_shift (
        .clk     (S_AXI_ACLK),
        .rst     (S_AXI_RESET),
        .start   (start),
        .cs_sel  (ctrl_new[CTRL_CS_LSB +: 3]),
        .tx      (txdata_q),
        .clkdiv  (clkdiv_q),
        .rd_mode (rd_mode_d),
        .rx      (rx),
        .busy    (busy),
        .done    (shift_done),
        .sclk    (spi_sclk),
        .sen_n   (spi_sen_n),
        .sdout   (spi_sdout),
        .sdin    (spi_sdin)
    );

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = awready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = RESP_OKAY;

    assign unused_ok = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0], s_axi.awprot,
                         s_axi.arprot, tx_new, ctrl_new, div_new, stat_clr};

endmodule
